// File: rtl/spi_bus_arbiter.sv
// Round-robin, burst-granular sharing of one SPI master between NUM_REQ requesters.
// Optional handshake watchdog with rsp_err_o: define SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_SS      = 4,
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = 2,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ*NUM_SS-1:0] req_ss_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      m_start_o,
  output logic [DATA_W-1:0]         m_tx_data_o,
  input  logic                      m_ready_i,
  input  logic [DATA_W-1:0]         m_rx_data_i,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic                      rsp_err_o,
`endif
  output logic [NUM_SS-1:0]         ss_n_o
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (SETUP_CYC < 1 || SETUP_CYC > 15 || GAP_CYC < 1 || GAP_CYC > 15 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("spi_bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETUP, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_RESP, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [OW-1:0]       owner_q, owner_d, ptr_q, ptr_d;
  logic [NUM_SS-1:0]   ss_q, ss_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   rsp_q, rsp_d;
  logic [OW-1:0]       pick_idx;
  logic                pick_ok;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                err_q, err_d;
`endif

  // First valid requester at or above the pointer, wrapping.
  always_comb begin
    int k;
    k        = 0;
    pick_idx = ptr_q;
    pick_ok  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!pick_ok && req_valid_i[k]) begin
        pick_ok  = 1'b1;
        pick_idx = OW'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    ss_d        = ss_q;
    grant_d     = grant_q;
    last_d      = last_q;
    rsp_d       = rsp_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    m_start_o   = 1'b0;
    m_tx_data_o = '0;
    ss_n_o      = '1;
    case (state_q)
      S_IDLE: if (|req_valid_i) state_d = S_ARB;
      S_ARB: begin
        if (pick_ok) begin
          owner_d           = pick_idx;
          ss_d              = req_ss_i[pick_idx*NUM_SS +: NUM_SS];
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          ptr_d             = OW'((int'(pick_idx) + 1) % NUM_REQ);
          state_d           = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        ss_n_o = ~ss_q;
        if (cnt_q == 4'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOAD: begin
        ss_n_o = ~ss_q;
        if (req_valid_i[owner_q] && m_ready_i) begin
          req_ready_o[owner_q] = 1'b1;
          m_start_o            = 1'b1;
          m_tx_data_o          = req_data_i[owner_q*DATA_W +: DATA_W];
          last_d               = req_last_i[owner_q];
          state_d              = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        ss_n_o = ~ss_q;
        if (!m_ready_i) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        ss_n_o = ~ss_q;
        if (m_ready_i) begin
          rsp_d   = m_rx_data_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ss_n_o               = ~ss_q;
        rsp_valid_o[owner_q] = 1'b1;
        if (last_q) begin
          grant_d = '0;
          state_d = S_GAP;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_GAP: begin
        if (cnt_q == 4'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SPI_ARB_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
    if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) begin
      wd_d = wd_q + 1'b1;
      // A real completion in the same cycle as expiry wins over the timeout.
      if (state_d == S_RESP) begin
        wd_d  = '0;
        err_d = 1'b0;
      end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        wd_d    = '0;
        err_d   = 1'b1;
        rsp_d   = '0;
        last_d  = 1'b1;
        state_d = S_RESP;
      end
    end
    rsp_err_o = (state_q == S_RESP) && err_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      ss_q    <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      rsp_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      ss_q    <= ss_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rsp_q   <= rsp_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign grant_o    = grant_q;
  assign rsp_data_o = rsp_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule
